// File: rtl/instr_fetch_mem_if.sv
// instr_fetch_mem_if: fetch request / response channels plus flush.
// master = fetch stage, slave = instruction memory.
interface instr_fetch_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: fetch-stage instruction memory. Ports: clk, rst_n,
// bus (req/rsp/flush, slave), wr_en/wr_addr/wr_data program load.
// Optional macro IMEM_RANGE_CHK_EN enables rsp_err range reporting.
module instr_fetch_mem #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 8192,
  parameter int                ADDR_W    = 15,
  parameter int                LATENCY   = 1,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_fetch_mem_if.slave  bus,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int IW = ADDR_W - 2;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // array read stage + LATENCY registers: visible after edge N+LATENCY
  localparam int NS = LATENCY + 1;
  localparam int FD = LATENCY + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              oor;
  } ent_t;

  if (LATENCY < 1 || LATENCY > 3) begin : g_lat_chk
    $error("instr_fetch_mem: LATENCY must be 1..3");
  end
  if (MW > IW) begin : g_depth_chk
    $error("instr_fetch_mem: DEPTH exceeds address range");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0] ridx;
  logic [IW-1:0] widx;
  logic          r_oor;
  logic          w_oor;
  logic          unused_lo;

  assign ridx  = bus.req_addr[ADDR_W-1:2];
  assign widx  = wr_addr[ADDR_W-1:2];
  assign r_oor = 32'(ridx) >= DEPTH;
  assign w_oor = 32'(widx) >= DEPTH;
  assign unused_lo = ^wr_addr[1:0];

  logic [NS-1:0] s_vld;
  ent_t          s_ent [NS];
  ent_t          fbuf  [FD];
  ent_t          rd_ent;
  ent_t          head;
  logic [1:0]    rp;
  logic [1:0]    wp;
  logic [2:0]    cnt;
  logic          pop;
  logic          pop_f;
  logic          push;
  logic          acc;
  int            occ;

  // FIFO head has priority; the last stage falls through when empty
  assign bus.rsp_valid = (cnt != 3'd0) || s_vld[NS-1];
  assign head  = (cnt != 3'd0) ? fbuf[rp] : s_ent[NS-1];
  assign pop   = bus.rsp_valid && bus.rsp_ready;
  assign pop_f = pop && (cnt != 3'd0);
  assign push  = s_vld[NS-1] && !(pop && cnt == 3'd0);

  always_comb begin
    occ = int'(cnt) + $countones(s_vld) - int'(pop);
  end

  assign bus.req_ready = (occ < FD) && !bus.flush;
  assign acc = bus.req_valid && bus.req_ready;

  always_comb begin
    rd_ent      = '0;
    rd_ent.data = r_oor ? NOP_WORD : mem[ridx[MW-1:0]];
    rd_ent.addr = bus.req_addr;
    rd_ent.oor  = r_oor;
  end

  // read captured at accept edge, so a same-edge write is not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_vld <= '0;
      for (int i = 0; i < NS; i++) s_ent[i] <= '0;
    end else begin
      s_vld <= {s_vld[NS-2:0], acc};
      if (bus.flush) s_vld <= '0;
      if (acc) s_ent[0] <= rd_ent;
      for (int i = 1; i < NS; i++) s_ent[i] <= s_ent[i-1];
    end
  end

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'(FD - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop_f) rp <= nxt(rp);
      cnt <= cnt + 3'(push) - 3'(pop_f);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fbuf[wp] <= s_ent[NS-1];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !w_oor) mem[widx[MW-1:0]] <= wr_data;
  end

  assign bus.rsp_instr = head.data;
  assign bus.rsp_addr  = head.addr;

`ifdef IMEM_RANGE_CHK_EN
  logic wr_flag;

  // a dropped out-of-range write stays visible until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_flag <= 1'b0;
    else if (wr_en && w_oor) wr_flag <= 1'b1;
  end

  assign bus.rsp_err = bus.rsp_valid && (head.oor || wr_flag);
`else
  assign bus.rsp_err = 1'b0;
`endif

endmodule
